// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - symbol codes and active-high segment patterns for the scan driver
package ssd_pkg;

    typedef logic [6:0] seg_t;

    localparam logic [4:0] SYM_BLANK = 5'h10;
    localparam logic [4:0] SYM_DASH  = 5'h11;
    localparam logic [4:0] SYM_L     = 5'h12;
    localparam logic [4:0] SYM_O     = 5'h13;

    // Segment order {g,f,e,d,c,b,a}, 1 = lit
    localparam seg_t SEG_OFF  = 7'h00;
    localparam seg_t SEG_DASH = 7'h40;
    localparam seg_t SEG_L    = 7'h38;
    localparam seg_t SEG_O    = 7'h5C;

    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/ssd_seg_decode.sv
// rtl/ssd_seg_decode.sv - combinational symbol to active-high segment decoder
module ssd_seg_decode
    import ssd_pkg::*;
#(
    parameter int SYM_W = 5
) (
    input  logic [SYM_W-1:0] sym,
    output seg_t             seg
);

    logic upper_zero;

    always_comb begin
        upper_zero = ((sym >> 5) == '0);
        seg        = SEG_OFF;
        if (upper_zero) begin
            if (!sym[4]) begin
                seg = SEG_HEX[sym[3:0]];
            end else begin
                case (sym[4:0])
                    SYM_DASH: seg = SEG_DASH;
                    SYM_L:    seg = SEG_L;
                    SYM_O:    seg = SEG_O;
                    default:  seg = SEG_OFF;
                endcase
            end
        end
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - multiplexed seven-segment scan driver with frame-synchronous update
// Optional blinking enabled by defining SSD_BLINK_EN.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SYM_W      = 5,
    parameter int PRESCALE   = 50000,
    parameter int ACTIVE_LOW = 1,
    parameter int BLINK_DIV  = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_DIGITS*SYM_W-1:0] sym_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic [NUM_DIGITS-1:0]       blank_in,
    input  logic                        load,
`ifdef SSD_BLINK_EN
    input  logic [NUM_DIGITS-1:0]       blink_in,
`endif
    output logic [NUM_DIGITS-1:0]       an_out,
    output logic [6:0]                  seg_out,
    output logic                        dp_out,
    output logic                        frame_tick
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] ILAST = IW'(NUM_DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [PW-1:0]               pcnt_q, pcnt_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [NUM_DIGITS*SYM_W-1:0] staged_sym_q, staged_sym_d, shadow_sym_q, shadow_sym_d;
    logic [NUM_DIGITS-1:0]       staged_dp_q, staged_dp_d, shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]       staged_blank_q, staged_blank_d, shadow_blank_q, shadow_blank_d;
    logic                        pending_q, pending_d;
    logic [NUM_DIGITS-1:0]       an_q, an_d;
    logic [6:0]                  seg_q, seg_d;
    logic                        dp_q, dp_d;
    logic                        frame_tick_q, frame_tick_d;

    logic                  boundary;
    logic                  dark;
    logic [SYM_W-1:0]      cur_sym;
    seg_t                  dec_seg;
    logic [NUM_DIGITS-1:0] an_act;
    seg_t                  seg_act;
    logic                  dp_act;

`ifdef SSD_BLINK_EN
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [FW-1:0] FLAST = FW'(BLINK_DIV - 1);

    logic [NUM_DIGITS-1:0] staged_blink_q, staged_blink_d, shadow_blink_q, shadow_blink_d;
    logic [FW-1:0]         fcnt_q, fcnt_d;
    logic                  phase_on_q, phase_on_d;

    assign dark = shadow_blank_q[idx_q] | (shadow_blink_q[idx_q] & ~phase_on_q);
`else
    assign dark = shadow_blank_q[idx_q];
`endif

    assign boundary = (idx_q == ILAST) && (pcnt_q == PLAST);
    assign cur_sym  = shadow_sym_q[idx_q*SYM_W +: SYM_W];

    // Single decoder on the currently scanned digit
    ssd_seg_decode #(.SYM_W(SYM_W)) u_decode (
        .sym (cur_sym),
        .seg (dec_seg)
    );

    always_comb begin
        pcnt_d         = pcnt_q + 1'b1;
        idx_d          = idx_q;
        staged_sym_d   = staged_sym_q;
        staged_dp_d    = staged_dp_q;
        staged_blank_d = staged_blank_q;
        shadow_sym_d   = shadow_sym_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        pending_d      = pending_q;
        frame_tick_d   = boundary;

        if (pcnt_q == PLAST) begin
            pcnt_d = '0;
            idx_d  = (idx_q == ILAST) ? '0 : idx_q + 1'b1;
        end

        if (load) begin
            staged_sym_d   = sym_in;
            staged_dp_d    = dp_in;
            staged_blank_d = blank_in;
            pending_d      = 1'b1;
        end

        // A load on the boundary cycle bypasses the staging registers
        if (boundary) begin
            pending_d = 1'b0;
            if (load) begin
                shadow_sym_d   = sym_in;
                shadow_dp_d    = dp_in;
                shadow_blank_d = blank_in;
            end else if (pending_q) begin
                shadow_sym_d   = staged_sym_q;
                shadow_dp_d    = staged_dp_q;
                shadow_blank_d = staged_blank_q;
            end
        end

        an_act  = '0;
        seg_act = SEG_OFF;
        dp_act  = 1'b0;
        if (pcnt_q != '0) begin
            an_act[idx_q] = 1'b1;
            if (!dark) begin
                seg_act = dec_seg;
                dp_act  = shadow_dp_q[idx_q];
            end
        end
        an_d  = an_act ^ {NUM_DIGITS{POL}};
        seg_d = seg_act ^ {7{POL}};
        dp_d  = dp_act ^ POL;
    end

`ifdef SSD_BLINK_EN
    always_comb begin
        staged_blink_d = staged_blink_q;
        shadow_blink_d = shadow_blink_q;
        fcnt_d         = fcnt_q;
        phase_on_d     = phase_on_q;
        if (load) begin
            staged_blink_d = blink_in;
        end
        if (boundary) begin
            if (load) begin
                shadow_blink_d = blink_in;
            end else if (pending_q) begin
                shadow_blink_d = staged_blink_q;
            end
            if (fcnt_q == FLAST) begin
                fcnt_d     = '0;
                phase_on_d = ~phase_on_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staged_blink_q <= '0;
            shadow_blink_q <= '0;
            fcnt_q         <= '0;
            phase_on_q     <= 1'b1;
        end else begin
            staged_blink_q <= staged_blink_d;
            shadow_blink_q <= shadow_blink_d;
            fcnt_q         <= fcnt_d;
            phase_on_q     <= phase_on_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q         <= '0;
            idx_q          <= '0;
            staged_sym_q   <= '0;
            staged_dp_q    <= '0;
            staged_blank_q <= '0;
            shadow_sym_q   <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            pending_q      <= 1'b0;
            an_q           <= {NUM_DIGITS{POL}};
            seg_q          <= {7{POL}};
            dp_q           <= POL;
            frame_tick_q   <= 1'b0;
        end else begin
            pcnt_q         <= pcnt_d;
            idx_q          <= idx_d;
            staged_sym_q   <= staged_sym_d;
            staged_dp_q    <= staged_dp_d;
            staged_blank_q <= staged_blank_d;
            shadow_sym_q   <= shadow_sym_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            pending_q      <= pending_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign an_out     = an_q;
    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - directed frame-by-frame checks of ssd_scan_driver, both polarities
module tb_ssd_scan_driver;

    typedef struct packed {
        logic [19:0] sym;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  blink;
        logic [27:0] seg_exp;
        logic [3:0]  dp_exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] sym_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  blink_in = '0;
    logic        load = 1'b0;
    logic [3:0]  an_lo, an_hi;
    logic [6:0]  seg_lo, seg_hi;
    logic        dp_lo, dp_hi, ft_lo, ft_hi;

    int n_vec = 0;
    int n_fail = 0;
    int k = -1;

    logic [3:0] an_lit [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    vec_t tab [4];
    vec_t zv, vb, vb_off;

    always #5 clk = ~clk;

    ssd_scan_driver #(.NUM_DIGITS(4), .SYM_W(5), .PRESCALE(4), .ACTIVE_LOW(1), .BLINK_DIV(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .dp_in(dp_in), .blank_in(blank_in), .load(load),
`ifdef SSD_BLINK_EN
        .blink_in(blink_in),
`endif
        .an_out(an_lo), .seg_out(seg_lo), .dp_out(dp_lo), .frame_tick(ft_lo)
    );

    ssd_scan_driver #(.NUM_DIGITS(4), .SYM_W(5), .PRESCALE(4), .ACTIVE_LOW(0), .BLINK_DIV(2)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .dp_in(dp_in), .blank_in(blank_in), .load(load),
`ifdef SSD_BLINK_EN
        .blink_in(blink_in),
`endif
        .an_out(an_hi), .seg_out(seg_hi), .dp_out(dp_hi), .frame_tick(ft_hi)
    );

    task automatic cmp(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d actual=%h expected=%h", name, k, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic check_inactive(input string tag);
        cmp({tag, "_an"}, {3'b0, an_lo}, 7'h0F);
        cmp({tag, "_seg"}, seg_lo, 7'h7F);
        cmp({tag, "_dp"}, {6'b0, dp_lo}, 7'h01);
        cmp({tag, "_ft"}, {6'b0, ft_lo}, 7'h00);
        cmp({tag, "_hi_an"}, {3'b0, an_hi}, 7'h00);
        cmp({tag, "_hi_seg"}, seg_hi, 7'h00);
        cmp({tag, "_hi_dp"}, {6'b0, dp_hi}, 7'h00);
        cmp({tag, "_hi_ft"}, {6'b0, ft_hi}, 7'h00);
    endtask

    task automatic check_edge(input vec_t e);
        int d, p;
        logic [3:0] an_e, an_h;
        logic [6:0] seg_e, seg_h;
        logic dp_e, dp_h, ft_e;
        d = (k / 4) % 4;
        p = k % 4;
        an_e = 4'hF;
        seg_e = 7'h7F;
        dp_e = 1'b1;
        if (p != 0) begin
            an_e = an_lit[d];
            seg_e = e.seg_exp[d*7 +: 7];
            dp_e = e.dp_exp[d];
        end
        ft_e = (k % 16 == 15);
        an_h = ~an_e;
        seg_h = ~seg_e;
        dp_h = ~dp_e;
        cmp("an", {3'b0, an_lo}, {3'b0, an_e});
        cmp("seg", seg_lo, seg_e);
        cmp("dp", {6'b0, dp_lo}, {6'b0, dp_e});
        cmp("frame_tick", {6'b0, ft_lo}, {6'b0, ft_e});
        cmp("hi_an", {3'b0, an_hi}, {3'b0, an_h});
        cmp("hi_seg", seg_hi, seg_h);
        cmp("hi_dp", {6'b0, dp_hi}, {6'b0, dp_h});
        cmp("hi_frame_tick", {6'b0, ft_hi}, {6'b0, ft_e});
    endtask

    task automatic apply(input vec_t v);
        sym_in = v.sym;
        dp_in = v.dp;
        blank_in = v.blank;
        blink_in = v.blink;
        load = 1'b1;
    endtask

    task automatic do_frame(input vec_t e, input int la1, input vec_t l1, input int la2, input vec_t l2);
        for (int i = 0; i < 16; i++) begin
            if (i == la1) apply(l1);
            else if (i == la2) apply(l2);
            else load = 1'b0;
            tick();
            check_edge(e);
        end
        load = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_inactive("reset");
        @(negedge clk);
        rst_n = 1'b1;
        k = -1;
    endtask

    task automatic mid_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_inactive(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = -1;
    endtask

    initial begin
        zv = '{sym: 20'h0, dp: 4'h0, blank: 4'h0, blink: 4'h0,
               seg_exp: {7'h40, 7'h40, 7'h40, 7'h40}, dp_exp: 4'hF};
        tab[0] = '{sym: {5'h03, 5'h02, 5'h01, 5'h00}, dp: 4'b0000, blank: 4'b0000, blink: 4'b0000,
                   seg_exp: {7'h30, 7'h24, 7'h79, 7'h40}, dp_exp: 4'b1111};
        tab[1] = '{sym: {5'h11, 5'h05, 5'h12, 5'h10}, dp: 4'b0001, blank: 4'b0100, blink: 4'b0000,
                   seg_exp: {7'h3F, 7'h7F, 7'h47, 7'h7F}, dp_exp: 4'b1110};
        tab[2] = '{sym: {5'h0E, 5'h0A, 5'h13, 5'h1F}, dp: 4'b0001, blank: 4'b0000, blink: 4'b0000,
                   seg_exp: {7'h06, 7'h08, 7'h23, 7'h7F}, dp_exp: 4'b1110};
        tab[3] = '{sym: {5'h0F, 5'h0D, 5'h0C, 5'h0B}, dp: 4'b1010, blank: 4'b1000, blink: 4'b0000,
                   seg_exp: {7'h7F, 7'h21, 7'h46, 7'h03}, dp_exp: 4'b1101};

        do_reset();
        do_frame(zv, -1, zv, -1, zv);

        // Each vector loaded mid-frame (idx=1): old set for rest of frame, new set next frame
        for (int i = 0; i < 4; i++) begin
            do_frame(i == 0 ? zv : tab[i-1], 5, tab[i], -1, zv);
        end
        do_frame(tab[3], -1, zv, -1, zv);

        // Boundary bypass, load two cycles later, then two loads in one frame
        do_frame(tab[3], 15, tab[1], -1, zv);
        do_frame(tab[1], 1, tab[0], -1, zv);
        do_frame(tab[0], 3, tab[2], 7, tab[3]);
        do_frame(tab[3], -1, zv, -1, zv);

        // Reset mid-frame with a load pending: staged data must be lost
        for (int i = 0; i < 8; i++) begin
            if (i == 5) apply(tab[2]);
            else load = 1'b0;
            tick();
            check_edge(tab[3]);
        end
        load = 1'b0;
        mid_reset("midreset");
        do_frame(zv, -1, zv, -1, zv);
        do_frame(zv, -1, zv, -1, zv);

`ifdef SSD_BLINK_EN
        vb = tab[0];
        vb.blink = 4'b0001;
        vb_off = vb;
        vb_off.seg_exp[6:0] = 7'h7F;
        do_reset();
        do_frame(zv, 5, vb, -1, zv);
        do_frame(vb, -1, zv, -1, zv);
        do_frame(vb_off, -1, zv, -1, zv);
        do_frame(vb_off, -1, zv, -1, zv);
        do_frame(vb, -1, zv, -1, zv);
        do_frame(vb, -1, zv, -1, zv);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_edge(vb_off);
        end
        mid_reset("blinkreset");
        do_frame(zv, 5, vb, -1, zv);
        do_frame(vb, -1, zv, -1, zv);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
